button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Upstream stage of the ALU board top level. Conditions the raw push-button inputs before they reach the ALU load logic.
- Per button, three steps:
  - synchronise the asynchronous pad signal;
  - debounce it with a stability counter;
  - emit a clean level plus a single-cycle press pulse.
- BTN_PULSE drives the ALU top's BUTTONS input, so each physical press loads DATOA, DATOB or OPCODE exactly once.

Parameters:
- N_BUTTONS, 3, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be >= 2.
- CNT_WIDTH, 20, width of each debounce counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 50000000, cycles from accepted press to first auto-repeat pulse (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN).
- RPT_WIDTH, 26, width of the repeat counter (used only with AUTOREPEAT_EN).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- BUTTONS_RAW  input  N_BUTTONS  asynchronous, bouncing button pads, active-high.
- BTN_LEVEL  output  N_BUTTONS  debounced button level.
- BTN_PULSE  output  N_BUTTONS  one-cycle pulse per accepted press (rising edge of BTN_LEVEL).

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - Reset is synchronous and active-high on RESET.
  - While RESET is sampled high: synchroniser flops, BTN_LEVEL, BTN_PULSE, debounce counters and repeat counters all become 0.
- Channels are fully independent; there is no cross-button priority. Simultaneous presses give simultaneous pulses, and priority stays in the downstream load logic.
- Synchroniser: 2-flop chain per bit, sync1 <= BUTTONS_RAW[i], sync2 <= sync1.
- Debounce counter, per channel, each cycle:
  - if sync2 == BTN_LEVEL[i]: cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1: BTN_LEVEL[i] <= sync2, cnt <= 0;
  - else: cnt <= cnt+1.
- Latency: raw first sampled high at edge k and held stable → BTN_LEVEL[i] rises after edge k+DEBOUNCE_CYCLES+1. The same latency applies to release.
- Glitch rejection: any bounce back to the current level before the count completes clears cnt, and counting restarts from 0. A disagreement lasting DEBOUNCE_CYCLES-1 cycles never changes BTN_LEVEL.
- BTN_PULSE[i]:
  - high for exactly the one cycle following the edge at which BTN_LEVEL[i] goes 0→1 (registered, same edge as the level update);
  - no pulse on release.
- No counter wraps: cnt is bounded by DEBOUNCE_CYCLES-1.
- Reset mid-operation: any partial count is discarded.
- Button held through reset deassertion: treated as a new press. BTN_LEVEL rises after DEBOUNCE_CYCLES+1 further cycles, with one BTN_PULSE.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined (auto-repeat on):
  - A per-channel repeat counter clears on the cycle BTN_LEVEL[i] rises and counts while BTN_LEVEL[i]=1.
  - Extra BTN_PULSE[i] cycles are emitted REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while held.
  - Release or reset clears the repeat counter immediately; no pending pulse is emitted.
  - Each repeat pulse is exactly one cycle wide.
- Not defined (no auto-repeat):
  - No repeat counters are synthesised; REPEAT_* and RPT_WIDTH are ignored.
  - Exactly one pulse per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset: hold RESET 3 cycles with BUTTONS_RAW=3'b111 → BTN_LEVEL=0 and BTN_PULSE=0 throughout reset.
- Clean press: BUTTONS_RAW[0] 0→1 first sampled at edge k → BTN_LEVEL[0]=1 after edge k+5; BTN_PULSE[0]=1 for that single cycle only; release gives no pulse.
- Bounce: BUTTONS_RAW[1] toggles 1,0,1,1,0 then holds 1 → no level change until 4 consecutive stable synchronised cycles; exactly one BTN_PULSE[1].
- Short glitch: BUTTONS_RAW[2] high for 3 cycles, then low → BTN_LEVEL[2] stays 0; no pulse.
- Simultaneous: all three raw bits rise on the same edge → BTN_PULSE=3'b111 for one cycle, 5 edges later.
- Reset mid-count (with BUTTON_AUTOREPEAT_EN also checked):
  - Assert RESET at cnt=2, held button → count restarts; pulse after 5 more edges.
  - With the macro defined, a hold of 20 cycles after the first pulse → repeat pulses at +10, +13, +16, +19.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button 2-flop sync, stability-counter debounce, level and press pulse
// Define BUTTON_AUTOREPEAT_EN to add held-button auto-repeat pulses on BTN_PULSE.
module button_conditioner #(
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int RPT_WIDTH       = 26
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N_BUTTONS-1:0] BUTTONS_RAW,
  output logic [N_BUTTONS-1:0] BTN_LEVEL,
  output logic [N_BUTTONS-1:0] BTN_PULSE
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] r_sync1;
  logic [N_BUTTONS-1:0] r_sync2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= BUTTONS_RAW;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_pulse;
    logic                 w_accept;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_rpt_fire;

    // A level change is accepted only on the cycle the counter completes.
    assign w_accept = (r_sync2[gi] != r_level) && (r_cnt == CNT_LAST);
    assign w_rise   = w_accept && !r_level;
    assign w_fall   = w_accept && r_level;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        if (r_sync2[gi] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_pulse <= w_rise | w_rpt_fire;
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [RPT_WIDTH-1:0] RPT_FIRE   = RPT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [RPT_WIDTH-1:0] RPT_RELOAD = RPT_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_WIDTH-1:0] r_rpt;

    // Reloading to DELAY-PERIOD reuses one compare for the first and later repeats.
    assign w_rpt_fire = r_level && !w_fall && (r_rpt == RPT_FIRE);

    always_ff @(posedge CLK) begin
      if (RESET || w_rise || w_fall || !r_level) begin
        r_rpt <= '0;
      end else if (w_rpt_fire) begin
        r_rpt <= RPT_RELOAD;
      end else begin
        r_rpt <= r_rpt + 1'b1;
      end
    end
`else
    logic w_unused_rpt;
    assign w_unused_rpt = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0) ^ (RPT_WIDTH > 0);
    assign w_rpt_fire   = 1'b0;
`endif

    assign BTN_LEVEL[gi] = r_level;
    assign BTN_PULSE[gi] = r_pulse;
  end

endmodule
